// File: rtl/reg_file_sb.sv
// Multi-read, dual-write register file with a per-register busy scoreboard.
// Same-cycle writes and busy clears can be forwarded to the read ports.
module reg_file_sb #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int NRD      = 2,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic                wr0_en,
   input  logic [AW-1:0]       wr0_addr,
   input  logic [XLEN-1:0]     wr0_data,
   input  logic                wr1_en,
   input  logic [AW-1:0]       wr1_addr,
   input  logic [XLEN-1:0]     wr1_data,
   input  logic                resv_en,
   input  logic [AW-1:0]       resv_addr,
   output logic [NREGS-1:0]    busy_vec
);

   logic [XLEN-1:0]  regFile_q [NREGS];
   logic [XLEN-1:0]  regFile_d [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   // Port 1 is applied after port 0 so it wins a collision; the reserve is
   // applied last so a new producer outlives a retiring one.
   always_comb begin
      regFile_d = regFile_q;
      busy_d    = busy_q;
      if (wr0_en) begin
         regFile_d[wr0_addr] = wr0_data;
         busy_d[wr0_addr]    = 1'b0;
      end
      if (wr1_en) begin
         regFile_d[wr1_addr] = wr1_data;
         busy_d[wr1_addr]    = 1'b0;
      end
      if (resv_en) begin
         busy_d[resv_addr] = 1'b1;
      end
      if (ZERO_REG) begin
         regFile_d[0] = '0;
         busy_d[0]    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int n = 0; n < NREGS; n++) begin
            regFile_q[n] <= '0;
         end
         busy_q <= '0;
      end else begin
         regFile_q <= regFile_d;
         busy_q    <= busy_d;
      end
   end

   assign busy_vec = busy_q;

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
      logic            busy;
      logic            hit0;
      logic            hit1;

      assign addr = rd_addr[p*AW +: AW];

      // Forwarding is suppressed during reset so reads see the cleared state.
      always_comb begin
         hit0 = BYPASS && !rst && wr0_en && (wr0_addr == addr);
         hit1 = BYPASS && !rst && wr1_en && (wr1_addr == addr);
         data = regFile_q[addr];
         busy = busy_q[addr];
         if (hit1) begin
            data = wr1_data;
         end else if (hit0) begin
            data = wr0_data;
         end
         if (hit0 || hit1) begin
            busy = resv_en && (resv_addr == addr);
         end
         if (ZERO_REG && (addr == '0)) begin
            data = '0;
            busy = 1'b0;
         end
      end

      assign rd_data[p*XLEN +: XLEN] = data;
      assign rd_busy[p]              = busy;
   end

endmodule
